fifo_flex: RTL
==============

// Module: fifo_flex
// PURPOSE
//  Parametrised synchronous FIFO; next generation of the team's 8x16 pulse-driven FIFO.
//  Adds any-depth wrap, selectable edge/level strobes, selectable read style, an occupancy output,
//  programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow errors.
//  Sits between command/UART front-ends and the LED/debug logic on the Tang Nano 20K, single clock domain.
// PARAMETERS
//  DATA_WIDTH  8   data word width, >=1
//  DEPTH       16  number of entries, >=2, need not be a power of 2
//  EDGE_MODE   1   1: act on rising edge of write_en/read_en; 0: act on every high cycle (level)
//  FWFT        1   1: first-word fall-through; 0: registered read (data one cycle after read)
//  AF_LEVEL    14  almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clock         in   1                  clock, all logic on rising edge
//  reset         in   1                  reset, asynchronous, active-high
//  clear         in   1                  synchronous flush: empties FIFO, errors kept
//  err_clr       in   1                  synchronous clear of overflow/underflow
//  write_en      in   1                  write request (edge or level per EDGE_MODE)
//  read_en       in   1                  read request (edge or level per EDGE_MODE)
//  data_in       in   DATA_WIDTH         write data, sampled on accepted write
//  data_out      out  DATA_WIDTH         read data
//  data_valid    out  1                  data_out holds valid data (see BEHAVIOUR)
//  full          out  1                  level == DEPTH
//  empty         out  1                  level == 0
//  almost_full   out  1                  level >= AF_LEVEL
//  almost_empty  out  1                  level <= AE_LEVEL
//  level         out  $clog2(DEPTH+1)    current occupancy
//  overflow      out  1                  sticky: write strobe while full
//  underflow     out  1                  sticky: read strobe while empty
// BEHAVIOUR
//  - Reset: pointers=0, level=0, data_out=0, data_valid=0, overflow=underflow=0, edge-history regs=0
//    (so a request already held high when reset releases counts as an edge); full=0, empty=1,
//    almost_empty=1, almost_full=0. Memory contents are not reset.
//  - Strobes: EDGE_MODE=1: wr_stb = write_en & ~write_en_q; same for rd_stb. EDGE_MODE=0: wr_stb = write_en.
//  - Accept: wr_acc = wr_stb & ~full & ~clear; rd_acc = rd_stb & ~empty & ~clear.
//    Full/empty are judged on the pre-edge level: no write-through when full, no read-through when empty.
//  - Pointers: wr_ptr/rd_ptr range 0..DEPTH-1; increment on accept; explicit wrap DEPTH-1 -> 0.
//  - Level: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
//  - Flags: all flags derive combinationally from the level register, so they change the cycle after an accept.
//  - FWFT=1: data_out = mem[rd_ptr] combinationally; data_valid = ~empty.
//    A word written into an empty FIFO appears one cycle after its write edge.
//  - FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 for exactly one cycle.
//    Otherwise data_valid <= 0 and data_out holds its last value. Latency is 1 cycle.
//  - Errors: overflow <= 1 on wr_stb & full & ~clear; underflow <= 1 on rd_stb & empty & ~clear.
//    err_clr clears both; a set condition in the same cycle as err_clr wins, and the flag stays 1.
//  - Clear: pointers=0, level=0, data_valid=0 next cycle. Write/read strobes in the same cycle are
//    dropped silently with no error. Edge-history regs keep tracking, so no false edge after clear.
//  - Reset asserted mid-operation: immediate return to reset values, regardless of clock.
// TESTING
//  1 DEPTH=16, EDGE=1, FWFT=1: write 16 pulses 0x00..0x0F -> full=1, level=16, almost_full from level 14.
//    A 17th pulse -> overflow=1, level stays 16.
//  2 Continue 1: 16 read pulses -> data_out 0x00..0x0F in order, empty=1; a 17th read -> underflow=1;
//    err_clr -> both errors 0.
//  3 DEPTH=5, EDGE=0: hold write_en 12 cycles with a counting data_in, then read 5 -> first 5 values
//    returned, overflow=1. Repeat 3 times to exercise pointer wrap at 4->0.
//  4 EDGE=1: hold write_en high 10 cycles -> exactly 1 word stored. With level=3, rising edges on write_en
//    and read_en in the same cycle -> level stays 3, no error flags.
//  5 FWFT=0: write 0xA5, then read pulse -> data_valid high for 1 cycle, one cycle after the read edge,
//    with data_out=0xA5; data_out holds 0xA5 afterwards.
//  6 level=7: assert clear together with a write -> level=0 and empty next cycle, no overflow.
//    Assert reset mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with selectable edge/level
// request strobes, first-word fall-through or registered read, an occupancy
// output, programmable almost-full/almost-empty flags, a synchronous flush and
// sticky overflow/underflow errors.
//
// Ports
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   clear             synchronous flush (errors are kept)
//   err_clr           synchronous clear of overflow/underflow
//   write_en, read_en requests, edge- or level-sensitive per EDGE_MODE
//   data_in           write data, sampled on an accepted write
//   data_out          read data
//   data_valid        data_out holds valid data
//   full, empty       level == DEPTH / level == 0
//   almost_full       level >= AF_LEVEL
//   almost_empty      level <= AE_LEVEL
//   level             current occupancy
//   overflow          sticky: write strobe while full
//   underflow         sticky: read strobe while empty
module fifo_flex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned EDGE_MODE  = 1,
    parameter int unsigned FWFT       = 1,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         err_clr,
    input  logic                         write_en,
    input  logic                         read_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic wr_stb, rd_stb;
    logic wr_acc, rd_acc;

    // Explicit wrap so any DEPTH works, not just powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Request strobes. History registers keep tracking through clear so a
    // request held across a flush does not produce a second edge; they reset
    // to 0 so a request already high at reset release counts as an edge.
    if (EDGE_MODE != 0) begin : g_edge
        logic we_hist_q, re_hist_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                we_hist_q <= 1'b0;
                re_hist_q <= 1'b0;
            end else begin
                we_hist_q <= write_en;
                re_hist_q <= read_en;
            end
        end

        assign wr_stb = write_en & ~we_hist_q;
        assign rd_stb = read_en  & ~re_hist_q;
    end else begin : g_level
        assign wr_stb = write_en;
        assign rd_stb = read_en;
    end

    // Flags come from the registered level only.
    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_acc = wr_stb & ~full  & ~clear;
    assign rd_acc = rd_stb & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        // A set condition takes priority over err_clr in the same cycle.
        if (wr_stb & full & ~clear)       ovf_d = 1'b1;
        else if (err_clr)                 ovf_d = 1'b0;
        if (rd_stb & empty & ~clear)      udf_d = 1'b1;
        else if (err_clr)                 udf_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to 0 while empty so the output
        // reads 0 out of reset even though the storage is uninitialised.
        assign data_out   = empty ? '0 : mem[rd_ptr_q];
        assign data_valid = ~empty;
    end else begin : g_regrd
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dv_q, dv_d;

        always_comb begin
            dout_d = dout_q;
            dv_d   = 1'b0;
            if (rd_acc) begin
                dout_d = mem[rd_ptr_q];
                dv_d   = 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dout_q <= dout_d;
                dv_q   <= dv_d;
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dv_q;
    end

endmodule
